// File: rtl/retire_watchdog_monitor_if.sv
// Retire-stream bundle: per-port commit valid and PC, driven by the core
// (master) and observed by the watchdog monitor (slave).
interface retire_watchdog_monitor_if #(
    parameter int NUM_RETIRE = 3,
    parameter int PC_WIDTH   = 64
);
    logic [NUM_RETIRE-1:0]          retire_vld;
    logic [NUM_RETIRE*PC_WIDTH-1:0] retire_pc;

    modport master (output retire_vld, output retire_pc);
    modport slave  (input  retire_vld, input  retire_pc);
endinterface

// File: rtl/retire_watchdog_monitor.sv
// Retire-stream monitor: cycle/retire counters, per-port last PC, no-commit
// watchdog, checkpoint PC match and exit-PC terminator. Every output is a flop.
module retire_watchdog_monitor #(
    parameter int NUM_RETIRE    = 3,
    parameter int PC_WIDTH      = 64,
    parameter int MATCH_WIDTH   = 32,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int CNT_WIDTH     = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    retire_watchdog_monitor_if.slave       rif,
    input  logic [TIMEOUT_WIDTH-1:0]       cfg_timeout,
    input  logic [MATCH_WIDTH-1:0]         cfg_match_pc,
    input  logic                           cfg_exit_en,
    input  logic [PC_WIDTH-1:0]            cfg_exit_pc,
    output logic [CNT_WIDTH-1:0]           sim_cycles,
    output logic [CNT_WIDTH-1:0]           retire_count,
    output logic [NUM_RETIRE*PC_WIDTH-1:0] last_pc,
    output logic [TIMEOUT_WIDTH-1:0]       idle_cnt,
    output logic [1:0]                     state,
    output logic                           match_pulse,
    output logic [15:0]                    match_cnt,
    output logic                           hang,
    output logic                           done,
    output logic [2:0]                     exit_port
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HANG = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of set valid bits, widened to the counter width.
    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_RETIRE-1:0] v);
        logic [CNT_WIDTH-1:0] acc;
        acc = {CNT_WIDTH{1'b0}};
        for (int i = 0; i < NUM_RETIRE; i++) begin
            acc = acc + CNT_WIDTH'(v[i]);
        end
        return acc;
    endfunction

    state_t                        state_q, state_d;
    logic [CNT_WIDTH-1:0]          sim_cycles_q, sim_cycles_d;
    logic [CNT_WIDTH-1:0]          retire_count_q, retire_count_d;
    logic [NUM_RETIRE*PC_WIDTH-1:0] last_pc_q, last_pc_d;
    logic [TIMEOUT_WIDTH-1:0]      idle_cnt_q, idle_cnt_d;
    logic                          match_pulse_q, match_pulse_d;
    logic [15:0]                   match_cnt_q, match_cnt_d;
    logic                          hang_q, hang_d;
    logic                          done_q, done_d;
    logic [2:0]                    exit_port_q, exit_port_d;

    logic                          commit_s;
    logic                          exit_hit_s;
    logic [2:0]                    exit_idx_s;
    logic                          match_hit_s;
    logic [TIMEOUT_WIDTH:0]        idle_inc_s;
    logic [TIMEOUT_WIDTH-1:0]      idle_sat_s;
    logic                          expire_s;

    // Per-cycle retire decode: commit, exit hit (lowest port wins), checkpoint hit.
    always_comb begin
        commit_s    = |rif.retire_vld;
        exit_hit_s  = 1'b0;
        exit_idx_s  = 3'd0;
        match_hit_s = 1'b0;
        // Scan downwards so the lowest matching port is the one left standing.
        for (int i = NUM_RETIRE - 1; i >= 0; i--) begin
            if (cfg_exit_en && rif.retire_vld[i] &&
                (rif.retire_pc[i*PC_WIDTH +: PC_WIDTH] == cfg_exit_pc)) begin
                exit_hit_s = 1'b1;
                exit_idx_s = 3'(i);
            end else begin
                exit_hit_s = exit_hit_s;
            end
            if (rif.retire_vld[i] &&
                (rif.retire_pc[i*PC_WIDTH +: MATCH_WIDTH] == cfg_match_pc)) begin
                match_hit_s = 1'b1;
            end else begin
                match_hit_s = match_hit_s;
            end
        end
    end

    // Watchdog arithmetic: idle count plus one, computed one bit wider so the
    // expiry compare and the saturation check never see a wrapped value.
    always_comb begin
        idle_inc_s = {1'b0, idle_cnt_q} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1};
        if (idle_inc_s[TIMEOUT_WIDTH]) begin
            idle_sat_s = idle_cnt_q;
        end else begin
            idle_sat_s = idle_inc_s[TIMEOUT_WIDTH-1:0];
        end
        expire_s = (state_q == ST_RUN) && !commit_s &&
                   (cfg_timeout != {TIMEOUT_WIDTH{1'b0}}) &&
                   (idle_inc_s >= {1'b0, cfg_timeout});
    end

    // Next-state logic for the run/hang/done FSM and everything it gates.
    always_comb begin
        state_d        = state_q;
        retire_count_d = retire_count_q;
        idle_cnt_d     = idle_cnt_q;
        hang_d         = hang_q;
        done_d         = done_q;
        exit_port_d    = exit_port_q;
        case (state_q)
            ST_WAIT: begin
                retire_count_d = retire_count_q + popcount(rif.retire_vld);
                if (exit_hit_s) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    exit_port_d = exit_idx_s;
                end else if (commit_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RUN: begin
                retire_count_d = retire_count_q + popcount(rif.retire_vld);
                if (commit_s) begin
                    idle_cnt_d = {TIMEOUT_WIDTH{1'b0}};
                end else begin
                    idle_cnt_d = idle_sat_s;
                end
                // Exit is checked first so it wins over a simultaneous expiry.
                if (exit_hit_s) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    exit_port_d = exit_idx_s;
                end else if (expire_s) begin
                    state_d = ST_HANG;
                    hang_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HANG: state_d = ST_HANG;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_WAIT;
        endcase
    end

    // State-independent bookkeeping: cycle counter, last-PC capture, checkpoint.
    always_comb begin
        sim_cycles_d  = sim_cycles_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        last_pc_d     = last_pc_q;
        for (int i = 0; i < NUM_RETIRE; i++) begin
            if (rif.retire_vld[i]) begin
                last_pc_d[i*PC_WIDTH +: PC_WIDTH] = rif.retire_pc[i*PC_WIDTH +: PC_WIDTH];
            end else begin
                last_pc_d[i*PC_WIDTH +: PC_WIDTH] = last_pc_q[i*PC_WIDTH +: PC_WIDTH];
            end
        end
        match_pulse_d = match_hit_s;
        if (match_hit_s && (match_cnt_q != 16'hFFFF)) begin
            match_cnt_d = match_cnt_q + 16'd1;
        end else begin
            match_cnt_d = match_cnt_q;
        end
    end

    // Register bank with synchronous reset; all outputs come straight from here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_WAIT;
            sim_cycles_q   <= {CNT_WIDTH{1'b0}};
            retire_count_q <= {CNT_WIDTH{1'b0}};
            last_pc_q      <= {(NUM_RETIRE*PC_WIDTH){1'b0}};
            idle_cnt_q     <= {TIMEOUT_WIDTH{1'b0}};
            match_pulse_q  <= 1'b0;
            match_cnt_q    <= 16'd0;
            hang_q         <= 1'b0;
            done_q         <= 1'b0;
            exit_port_q    <= 3'd0;
        end else begin
            state_q        <= state_d;
            sim_cycles_q   <= sim_cycles_d;
            retire_count_q <= retire_count_d;
            last_pc_q      <= last_pc_d;
            idle_cnt_q     <= idle_cnt_d;
            match_pulse_q  <= match_pulse_d;
            match_cnt_q    <= match_cnt_d;
            hang_q         <= hang_d;
            done_q         <= done_d;
            exit_port_q    <= exit_port_d;
        end
    end

    assign sim_cycles   = sim_cycles_q;
    assign retire_count = retire_count_q;
    assign last_pc      = last_pc_q;
    assign idle_cnt     = idle_cnt_q;
    assign state        = state_q;
    assign match_pulse  = match_pulse_q;
    assign match_cnt    = match_cnt_q;
    assign hang         = hang_q;
    assign done         = done_q;
    assign exit_port    = exit_port_q;

endmodule
